seq_state_monitor: RTL and testbench
====================================

Name: seq_state_monitor

Overview:
- Receiver/checker for the 2-bit phase value driven by the team's three-phase sequencer (phases 0→1→2→0, with pause-hold and restart-to-0).
- Samples the phase value every clock and decodes it to one-hot.
- Flags phase changes and restarts, counts completed cycles, and detects illegal transitions and stalls.
- Sits directly downstream of the sequencer; feeds display/status logic.

Parameters:
- CNT_W, 8, width of completed-cycle counter oCiclos
- STALL_LIMIT, 16, consecutive same-value edges before oEstancado asserts (1..2^STALL_W-1)
- STALL_W, 5, width of internal stall counter

Ports:
- iClk  in  1  clock, rising edge
- iRst_n  in  1  reset, asynchronous, active-low
- iValorEstado  in  2  phase value from sequencer (0,1,2 legal; 3 illegal)
- iClear  in  1  synchronous clear of oCiclos, oError, stall counter; returns FSM to SYNC
- oFase  out  3  registered one-hot phase: bit0=phase0, bit1=phase1, bit2=phase2; 000 while in SYNC or on value 3
- oCambio  out  1  one-cycle pulse: legal phase change accepted
- oReinicio  out  1  one-cycle pulse: restart transition 1→0 accepted
- oCiclos  out  CNT_W  count of completed cycles (2→0 transitions), wraps at 2^CNT_W
- oError  out  1  sticky illegal-transition flag
- oEstancado  out  1  level: phase held ≥ STALL_LIMIT edges in TRACK

Behaviour:
- Reset (iRst_n=0, async):
  - FSM=SYNC, rPrev=0, stall count=0.
  - oFase=000, oCambio=0, oReinicio=0, oCiclos=0, oError=0, oEstancado=0.
  - Outputs go to these values immediately, without waiting for a clock edge.
- Timing: all outputs are registered. Response to the iValorEstado value sampled at edge N is visible after edge N. rPrev is updated every edge.
- FSM SYNC:
  - Ignores all values and no errors are raised.
  - On sampled value 0 → TRACK, oFase=001.
  - No oCambio on this entry.
- FSM TRACK, comparing sample v against rPrev:
  - v==rPrev: hold. Stall count increments, saturating at 2^STALL_W-1. oEstancado=1 when count ≥ STALL_LIMIT.
  - 0→1 or 1→2: legal. oCambio=1, stall count=0, oEstancado=0.
  - 2→0: legal completion. oCambio=1, oCiclos+1 (wraps), stall count=0.
  - 1→0: legal restart. oCambio=1, oReinicio=1, oCiclos unchanged, stall count=0.
  - 0→2, 2→1, or any v==3: illegal. oError=1 (sticky), FSM→SYNC, oFase=000, oCambio=0, stall count=0, oEstancado=0.
- oFase in TRACK is the one-hot of v.
- Pulses oCambio and oReinicio last exactly one cycle and never coincide with oError setting.
- iClear:
  - Highest priority below reset; overrides any event on the same edge.
  - Clears oCiclos, oError, oEstancado, the pulses and the stall count; FSM→SYNC; oFase=000.
  - rPrev still loads v.
- iClear held high: stays in SYNC with all status at 0.
- Reset mid-cycle: everything returns to reset values. On release, SYNC requires a fresh 0 before any counting.
- Stall counter is cleared on every FSM transition.

Test Plan:
- Reset release, drive 0,1,2,0,1,2,0 one per clock → oFase 001,010,100,001,…; oCambio high after each change; oCiclos=2; oError=0.
- From TRACK with phase 1, drive 0 → oReinicio=1 and oCambio=1 for one cycle; oCiclos unchanged.
- Hold phase 2 for 20 edges with STALL_LIMIT=16 → oEstancado rises after the 16th hold edge. Then drive 0 → oEstancado=0, oCiclos+1.
- Drive 0→2 → oError=1, oFase=000, no oCambio. Subsequent 1,2 ignored until 0 seen. oError stays 1 until iClear pulse, then 0.
- Drive value 3 in TRACK → oError=1 and SYNC. With CNT_W=2, complete 4 cycles → oCiclos wraps 3→0.
- Assert iRst_n=0 between clock edges during phase 1 → all outputs 0 immediately. Release, drive 1,2 → oFase stays 000 until 0 is sampled.

Source files
------------

// File: rtl/seq_state_monitor.sv
// seq_state_monitor: checks the three-phase sequencer output and reports phase, changes, cycles, errors and stalls
// Ports: iClk/iRst_n clock and async active-low reset; iValorEstado sampled phase (3 is illegal);
// iClear sync clear back to SYNC; oFase one-hot phase; oCambio/oReinicio one-cycle pulses;
// oCiclos completed 2->0 cycles; oError sticky illegal-transition flag; oEstancado stall level.
module seq_state_monitor #(
  parameter int CNT_W       = 8,
  parameter int STALL_LIMIT = 16,
  parameter int STALL_W     = 5
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic [1:0]       iValorEstado,
  input  logic             iClear,
  output logic [2:0]       oFase,
  output logic             oCambio,
  output logic             oReinicio,
  output logic [CNT_W-1:0] oCiclos,
  output logic             oError,
  output logic             oEstancado
);
  typedef enum logic {SYNC, TRACK} state_t;
  state_t state_q, state_d;
  logic [1:0] prev_q;
  logic [STALL_W-1:0] stall_q, stall_d, stall_inc;
  logic [2:0] fase_q, fase_d, onehot;
  logic cambio_q, cambio_d, reinicio_q, reinicio_d, error_q, error_d, estancado_q, estancado_d;
  logic [CNT_W-1:0] ciclos_q, ciclos_d;
  logic hold, fwd, wrap, restart;
  always_comb begin
    onehot    = (iValorEstado == 2'd3) ? 3'b000 : 3'b001 << iValorEstado;
    hold      = (iValorEstado == prev_q) && (iValorEstado != 2'd3);
    fwd       = (prev_q == 2'd0 && iValorEstado == 2'd1) || (prev_q == 2'd1 && iValorEstado == 2'd2);
    wrap      = prev_q == 2'd2 && iValorEstado == 2'd0;
    restart   = prev_q == 2'd1 && iValorEstado == 2'd0;
    stall_inc = (stall_q == {STALL_W{1'b1}}) ? stall_q : stall_q + 1'b1;
    state_d     = state_q;
    fase_d      = 3'b000;
    cambio_d    = 1'b0;
    reinicio_d  = 1'b0;
    ciclos_d    = ciclos_q;
    error_d     = error_q;
    stall_d     = '0;
    estancado_d = 1'b0;
    if (iClear) begin
      state_d  = SYNC;
      ciclos_d = '0;
      error_d  = 1'b0;
    end else if (state_q == SYNC) begin
      // Only a fresh phase 0 can resynchronise; everything else is ignored silently
      if (iValorEstado == 2'd0) begin
        state_d = TRACK;
        fase_d  = 3'b001;
      end
    end else if (hold) begin
      stall_d     = stall_inc;
      estancado_d = stall_inc >= STALL_W'(STALL_LIMIT);
      fase_d      = onehot;
    end else if (fwd || wrap || restart) begin
      cambio_d   = 1'b1;
      reinicio_d = restart;
      ciclos_d   = ciclos_q + CNT_W'(wrap);
      fase_d     = onehot;
    end else begin
      error_d = 1'b1;
      state_d = SYNC;
    end
  end
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q     <= SYNC;
      prev_q      <= 2'd0;
      stall_q     <= '0;
      fase_q      <= 3'b000;
      cambio_q    <= 1'b0;
      reinicio_q  <= 1'b0;
      ciclos_q    <= '0;
      error_q     <= 1'b0;
      estancado_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q      <= iValorEstado;
      stall_q     <= stall_d;
      fase_q      <= fase_d;
      cambio_q    <= cambio_d;
      reinicio_q  <= reinicio_d;
      ciclos_q    <= ciclos_d;
      error_q     <= error_d;
      estancado_q <= estancado_d;
    end
  end
  assign oFase      = fase_q;
  assign oCambio    = cambio_q;
  assign oReinicio  = reinicio_q;
  assign oCiclos    = ciclos_q;
  assign oError     = error_q;
  assign oEstancado = estancado_q;
endmodule

// File: tb/tb_seq_state_monitor.sv
// tb_seq_state_monitor: scoreboard bench comparing seq_state_monitor against a behavioural phase-checker model
module tb_seq_state_monitor;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] valor = 2'd0;
  logic clr = 1'b0;
  logic [2:0] fase;
  logic cambio, reinicio, err, est;
  logic [1:0] ciclos;
  int checks = 0;
  int errors = 0;
  logic [8:0] sb[$];
  bit m_sync;
  logic [1:0] m_prev;
  int m_stall, m_cyc;
  bit m_err;
  logic [8:0] exp_word;

  seq_state_monitor #(.CNT_W(2), .STALL_LIMIT(16), .STALL_W(5)) dut (
    .iClk(clk), .iRst_n(rst_n), .iValorEstado(valor), .iClear(clr),
    .oFase(fase), .oCambio(cambio), .oReinicio(reinicio), .oCiclos(ciclos),
    .oError(err), .oEstancado(est)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] outs();
    return {fase, cambio, reinicio, ciclos, err, est};
  endfunction

  task automatic model_reset();
    m_sync = 1; m_prev = 0; m_stall = 0; m_cyc = 0; m_err = 0;
  endtask

  function automatic logic [8:0] model_step(input logic [1:0] v, input bit c);
    logic [2:0] f;
    bit ch, rs, es;
    f = 0; ch = 0; rs = 0; es = 0;
    if (c) begin
      m_sync = 1; m_stall = 0; m_cyc = 0; m_err = 0;
    end else if (m_sync) begin
      m_stall = 0;
      if (v == 0) begin m_sync = 0; f = 3'b001; end
    end else if (v == 3 || (m_prev == 0 && v == 2) || (m_prev == 2 && v == 1)) begin
      m_err = 1; m_sync = 1; m_stall = 0;
    end else begin
      f = 3'b001 << v;
      if (v == m_prev) begin
        m_stall = (m_stall < 31) ? m_stall + 1 : 31;
        es = m_stall >= 16;
      end else begin
        m_stall = 0; ch = 1;
        rs = (m_prev == 1 && v == 0);
        if (m_prev == 2 && v == 0) m_cyc = (m_cyc + 1) % 4;
      end
    end
    m_prev = v;
    return {f, ch, rs, 2'(m_cyc), m_err, es};
  endfunction

  task automatic step(input string tag, input logic [1:0] v, input bit c = 0);
    @(negedge clk);
    valor = v; clr = c;
    sb.push_back(model_step(v, c));
    @(posedge clk);
    #1;
    exp_word = sb.pop_front();
    chk(tag, 16'(outs()), 16'(exp_word));
  endtask

  initial begin
    model_reset();
    #12;
    chk("reset_state", 16'(outs()), 16'd0);
    @(negedge clk); rst_n = 1'b1;
    foreach (sb[i]) sb.delete(i);
    for (int i = 0; i < 7; i++) step("basic_seq", 2'(i % 3));
    chk("basic_cycles", 16'(ciclos), 16'd2);
    step("r_to1", 2'd1);
    step("restart", 2'd0);
    chk("restart_pulse", 16'({cambio, reinicio}), 16'b11);
    step("r_after", 2'd1);
    step("to2", 2'd2);
    for (int i = 0; i < 20; i++) step($sformatf("hold%0d", i + 1), 2'd2);
    chk("stall_level", 16'(est), 16'd1);
    step("stall_exit", 2'd0);
    chk("stall_clear", 16'(est), 16'd0);
    step("illegal02", 2'd2);
    chk("illegal_err", 16'({err, fase, cambio}), 16'b10000);
    step("sync_ign1", 2'd1);
    step("sync_ign2", 2'd2);
    step("resync0", 2'd0);
    step("err_sticky", 2'd1);
    step("clear_over", 2'd2, 1);
    chk("clear_err", 16'(err), 16'd0);
    step("clear_held", 2'd0, 1);
    step("clear_held2", 2'd0, 1);
    step("re0", 2'd0);
    step("to1", 2'd1);
    step("illegal3", 2'd3);
    step("after3", 2'd0);
    for (int i = 0; i < 12; i++) step("wrap_cyc", 2'((i + 1) % 3));
    chk("wrap_zero", 16'(ciclos), 16'd0);
    step("clr_prio_a", 2'd1);
    step("clr_prio_b", 2'd2);
    step("clr_prio_c", 2'd0, 1);
    step("pre_rst0", 2'd0);
    step("pre_rst1", 2'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_rst", 16'(outs()), 16'd0);
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    step("post_rst1", 2'd1);
    step("post_rst2", 2'd2);
    step("post_rst0", 2'd0);
    step("post_rst_to1", 2'd1);
    step("sat_2a", 2'd2);
    for (int i = 0; i < 40; i++) step("sat_hold", 2'd2);
    step("sat_exit", 2'd0);
    chk("sb_empty", 16'(sb.size()), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
